// File: rtl/prog_loader_if.sv
// Host-to-loader byte stream plus the instruction-memory write port and status flags.
// The host side drives start/rx_*; the loader drives everything else.
interface prog_loader_if;
  logic        start;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        we;
  logic [31:0] d;
  logic [8:0]  a;
  logic        exec;
  logic        busy;
  logic        done;
  logic        err;

  modport master (
    output start, rx_data, rx_valid,
    input  rx_ready, we, d, a, exec, busy, done, err
  );

  modport slave (
    input  start, rx_data, rx_valid,
    output rx_ready, we, d, a, exec, busy, done, err
  );
endinterface

// File: rtl/prog_loader.sv
// Program loader: receives a length-prefixed, checksummed byte frame and writes
// big-endian 32-bit words into instruction memory, enabling execution on success.
module prog_loader (
  input  logic          clk,
  input  logic          rst,
  prog_loader_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE, LEN_HI, LEN_LO, DATA, WRITE, CHK, RUN, ERROR
  } state_t;

  state_t      state, state_nxt;
  logic [15:0] len;
  logic [9:0]  idx;
  logic [1:0]  byte_cnt;
  logic [23:0] word;
  logic [7:0]  acc;
  logic [31:0] d_q;
  logic [8:0]  a_q;
  logic        done_q;

  logic        rdy;
  logic        accept;
  logic        rearm;
  logic [15:0] len_rx;
  logic [15:0] idx_inc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // idx counts completed writes; the WRITE cycle compares the post-increment value to N.
  always_comb begin
    state_nxt = state;
    rdy       = 1'b0;
    rearm     = 1'b0;
    len_rx    = {len[15:8], bus.rx_data};
    idx_inc   = {6'd0, idx} + 16'd1;
    unique case (state)
      IDLE, RUN, ERROR: begin
        if (bus.start) begin
          rearm     = 1'b1;
          state_nxt = LEN_HI;
        end
      end
      LEN_HI: begin
        rdy = 1'b1;
        if (bus.rx_valid) state_nxt = LEN_LO;
      end
      LEN_LO: begin
        rdy = 1'b1;
        if (bus.rx_valid) begin
          if (len_rx == 16'd0 || len_rx > 16'd512) state_nxt = ERROR;
          else                                     state_nxt = DATA;
        end
      end
      DATA: begin
        rdy = 1'b1;
        if (bus.rx_valid && byte_cnt == 2'd3) state_nxt = WRITE;
      end
      WRITE: begin
        if (idx_inc == len) state_nxt = CHK;
        else                state_nxt = DATA;
      end
      CHK: begin
        rdy = 1'b1;
        if (bus.rx_valid) begin
          if (bus.rx_data == acc) state_nxt = RUN;
          else                    state_nxt = ERROR;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign accept = rdy & bus.rx_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len      <= '0;
      idx      <= '0;
      byte_cnt <= '0;
      word     <= '0;
      acc      <= '0;
      d_q      <= '0;
      a_q      <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (rearm) begin
        len      <= '0;
        idx      <= '0;
        byte_cnt <= '0;
        acc      <= '0;
      end
      if (state == LEN_HI && accept) len[15:8] <= bus.rx_data;
      if (state == LEN_LO && accept) len[7:0]  <= bus.rx_data;
      // The write port is latched on the 4th byte so d/a are stable through WRITE and after it.
      if (state == DATA && accept) begin
        word     <= {word[15:0], bus.rx_data};
        acc      <= acc ^ bus.rx_data;
        byte_cnt <= byte_cnt + 2'd1;
        if (byte_cnt == 2'd3) begin
          d_q <= {word, bus.rx_data};
          a_q <= idx[8:0];
        end
      end
      if (state == WRITE) idx <= idx + 10'd1;
      if (state == CHK && accept && bus.rx_data == acc) done_q <= 1'b1;
    end
  end

  assign bus.rx_ready = rdy;
  assign bus.we       = (state == WRITE);
  assign bus.d        = d_q;
  assign bus.a        = a_q;
  assign bus.exec     = (state == RUN);
  assign bus.err      = (state == ERROR);
  assign bus.busy     = !(state == IDLE || state == RUN || state == ERROR);
  assign bus.done     = done_q;

endmodule
